// File: rtl/xadc_axi_burst_capture.sv
// xadc_axi_burst_capture: buffers tagged samples in a FIFO and writes them as fixed-length AXI4 bursts into a ring or one-shot buffer
module xadc_axi_burst_capture #(
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_BURST_LEN = 16,
    parameter int C_NUM_CHANNELS = 4,
    parameter int C_FIFO_DEPTH = 64,
    parameter int C_BUF_WORDS = 1024,
    localparam int CW = C_NUM_CHANNELS > 1 ? $clog2(C_NUM_CHANNELS) : 1
)(
    input  logic ACLK,
    input  logic ARESET,
    input  logic INIT_AXI_TXN,
    input  logic CFG_CONTINUOUS,
    input  logic STOP,
    input  logic S_VALID,
    output logic S_READY,
    input  logic [15:0] S_DATA,
    input  logic [CW-1:0] S_CHAN,
    output logic TXN_DONE,
    output logic ERROR,
    output logic OVERFLOW,
    output logic [0:0] M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [7:0] M_AXI_AWLEN,
    output logic [2:0] M_AXI_AWSIZE,
    output logic [1:0] M_AXI_AWBURST,
    output logic M_AXI_AWLOCK,
    output logic [3:0] M_AXI_AWCACHE,
    output logic [2:0] M_AXI_AWPROT,
    output logic [3:0] M_AXI_AWQOS,
    output logic M_AXI_AWVALID,
    input  logic M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0] M_AXI_WSTRB,
    output logic M_AXI_WLAST,
    output logic M_AXI_WVALID,
    input  logic M_AXI_WREADY,
    input  logic [1:0] M_AXI_BRESP,
    input  logic M_AXI_BVALID,
    output logic M_AXI_BREADY
);
    localparam int FW = $clog2(C_FIFO_DEPTH);
    localparam int FW1 = FW + 1;
    localparam int PW = $clog2(C_BUF_WORDS);
    localparam int BW = $clog2(C_M_AXI_BURST_LEN) + 1;
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int LB = C_M_AXI_BURST_LEN - 1;
    localparam logic [FW:0] LEN_F = C_M_AXI_BURST_LEN[FW:0];
    localparam logic [PW-1:0] LEN_P = C_M_AXI_BURST_LEN[PW-1:0];
    localparam logic [PW:0] ACC_MAX = C_BUF_WORDS[PW:0];
    localparam logic [BW-1:0] LAST_BEAT = LB[BW-1:0];
    localparam logic [AW-1:0] BASE = AW'(C_M_TARGET_SLAVE_BASE_ADDR);

    typedef enum logic [2:0] {IDLE, FILL, ADDR, DATA, RESP, DONE} state_t;
    state_t state;

    logic [31:0] mem [C_FIFO_DEPTH];
    logic [FW:0] wp, rp, wp_n, count;
    logic [PW-1:0] word_ptr, ptr_n;
    logic [PW:0] acc;
    logic [BW-1:0] beat;
    logic cont, init_q, capturing, full, push, pop, start, to_done;

    assign count = wp - rp;
    assign full = count[FW];
    assign capturing = state inside {FILL, ADDR, DATA, RESP};
    assign S_READY = capturing && !full && (cont || acc < ACC_MAX);
    assign push = S_VALID && S_READY;
    assign pop = M_AXI_WVALID && M_AXI_WREADY;
    assign wp_n = wp + FW1'(push);
    assign start = INIT_AXI_TXN && !init_q && (state == IDLE || state == DONE);
    // word_ptr is exactly PW bits wide, so this add wraps modulo the buffer size
    assign ptr_n = word_ptr + LEN_P;
    assign to_done = cont ? STOP : ptr_n == '0;

    assign M_AXI_AWID = 1'b0;
    assign M_AXI_AWADDR = BASE + (AW'(word_ptr) << 2);
    assign M_AXI_AWLEN = 8'(LB);
    assign M_AXI_AWSIZE = 3'b010;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK = 1'b0;
    assign M_AXI_AWCACHE = 4'b0010;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_AWQOS = 4'b0000;
    assign M_AXI_AWVALID = state == ADDR;
    assign M_AXI_WDATA = mem[rp[FW-1:0]];
    assign M_AXI_WSTRB = 4'hF;
    assign M_AXI_WVALID = state == DATA;
    assign M_AXI_WLAST = M_AXI_WVALID && beat == LAST_BEAT;
    assign M_AXI_BREADY = state == RESP;
    assign TXN_DONE = state == DONE;

    always_ff @(posedge ACLK)
        if (push) mem[wp[FW-1:0]] <= {16'(S_CHAN), S_DATA};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
            wp <= '0;
            rp <= '0;
            word_ptr <= '0;
            acc <= '0;
            beat <= '0;
            cont <= 1'b0;
            init_q <= 1'b0;
            ERROR <= 1'b0;
            OVERFLOW <= 1'b0;
        end else begin
            init_q <= INIT_AXI_TXN;
            wp <= wp_n;
            rp <= rp + FW1'(pop);
            acc <= acc + (PW+1)'(push && !cont);
            if (capturing && S_VALID && full) OVERFLOW <= 1'b1;
            // flushing sets rp to the post-push write pointer so a same-cycle push is discarded too
            case (state)
                IDLE, DONE: if (start) begin
                    ERROR <= 1'b0;
                    OVERFLOW <= 1'b0;
                    rp <= wp;
                    word_ptr <= '0;
                    acc <= '0;
                    cont <= CFG_CONTINUOUS;
                    state <= FILL;
                end
                FILL: if (count >= LEN_F) state <= ADDR;
                      else if (cont && STOP) begin
                          state <= DONE;
                          rp <= wp_n;
                      end
                ADDR: if (M_AXI_AWREADY) begin
                    state <= DATA;
                    beat <= '0;
                end
                DATA: if (M_AXI_WREADY) begin
                    beat <= beat + BW'(1);
                    if (M_AXI_WLAST) state <= RESP;
                end
                RESP: if (M_AXI_BVALID) begin
                    ERROR <= ERROR | (M_AXI_BRESP != 2'b00);
                    word_ptr <= ptr_n;
                    state <= to_done ? DONE : FILL;
                    if (to_done) rp <= wp_n;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/xadc_axi_burst_capture.md
XADC_AXI_BURST_CAPTURE -- requirements
Module: xadc_axi_burst_capture

Interface
REQ-001 The block SHALL have parameter C_M_TARGET_SLAVE_BASE_ADDR, default 32'h4000_0000, byte base of the capture buffer, aligned to 4*C_BUF_WORDS.
REQ-002 The block SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-003 The block SHALL have parameter C_M_AXI_BURST_LEN, default 16, beats per burst, power of 2 in 1..256, with 4*C_M_AXI_BURST_LEN <= 4096.
REQ-004 The block SHALL have parameter C_NUM_CHANNELS, default 4, sample channels, 1..16.
REQ-005 The block SHALL have parameter C_FIFO_DEPTH, default 64, sample FIFO entries, power of 2, >= 2*C_M_AXI_BURST_LEN.
REQ-006 The block SHALL have parameter C_BUF_WORDS, default 1024, buffer size in 32-bit words, power of 2, multiple of C_M_AXI_BURST_LEN.
REQ-007 The block SHALL have ports, one per line:
  ACLK  in  1  clock, all logic on rising edge
  ARESET  in  1  synchronous active-high reset
  INIT_AXI_TXN  in  1  rising edge starts a capture
  CFG_CONTINUOUS  in  1  sampled at start; 1 = ring mode, 0 = one-shot
  STOP  in  1  level; ends a continuous capture
  S_VALID / S_READY  in / out  1 / 1  sample handshake
  S_DATA  in  16  sample value
  S_CHAN  in  max(1,clog2(C_NUM_CHANNELS))  channel tag
  TXN_DONE  out  1  capture finished (level)
  ERROR  out  1  sticky, any BRESP != OKAY
  OVERFLOW  out  1  sticky, sample offered while FIFO full
  M_AXI AW: AWADDR(C_M_AXI_ADDR_WIDTH), AWLEN 8, AWSIZE 3, AWBURST 2, AWVALID out; AWREADY in
  M_AXI W: WDATA 32, WSTRB 4, WLAST, WVALID out; WREADY in
  M_AXI B: BRESP 2, BVALID in; BREADY out
REQ-008 AWID=0, AWLOCK=0, AWCACHE=4'b0010, AWPROT=0, AWQOS=0, AWSIZE=3'b010, AWBURST=2'b01, AWLEN=C_M_AXI_BURST_LEN-1, WSTRB=4'hF SHALL be constant; no read channel.

Function
REQ-009 FSM states SHALL be IDLE, FILL, ADDR, DATA, RESP, DONE.
REQ-010 A start SHALL be INIT_AXI_TXN high with its registered value low, honoured only in IDLE or DONE; it clears ERROR, OVERFLOW, TXN_DONE, flushes the FIFO, zeroes word pointer and accepted-count, latches CFG_CONTINUOUS, enters FILL.
REQ-011 Capturing SHALL mean state in {FILL, ADDR, DATA, RESP}; S_READY = capturing and FIFO not full and (continuous or accepted-count < C_BUF_WORDS).
REQ-012 An accepted sample SHALL be pushed as WDATA = {zero-extended S_CHAN in [31:16], S_DATA in [15:0]}, one entry per S_VALID&&S_READY cycle.
REQ-013 OVERFLOW SHALL set when capturing and S_VALID and FIFO full; the sample is discarded.
REQ-014 FILL->ADDR SHALL occur when FIFO count >= C_M_AXI_BURST_LEN; FILL->DONE when STOP (continuous) is high and no burst is pending.
REQ-015 In ADDR, AWVALID SHALL be high with AWADDR = base + 4*word_ptr until AWREADY; then DATA.
REQ-016 In DATA, WVALID SHALL be high with FIFO head; pop on WVALID&&WREADY; WLAST high on beat C_M_AXI_BURST_LEN-1; after last beat, RESP.
REQ-017 In RESP, BREADY SHALL be high; on BVALID, ERROR |= (BRESP != 2'b00), word_ptr += C_M_AXI_BURST_LEN modulo C_BUF_WORDS.
REQ-018 After RESP: one-shot SHALL go DONE when C_BUF_WORDS words written, else FILL; continuous SHALL go DONE if STOP high, else FILL (ring wrap to base).
REQ-019 STOP SHALL never abort an in-flight burst; the burst completes through RESP.
REQ-020 Only one burst SHALL be outstanding; AW precedes W.
REQ-021 TXN_DONE SHALL be high exactly while in DONE; FIFO residue is discarded on entering DONE.
REQ-022 Simultaneous push and pop SHALL leave FIFO count unchanged.

Reset
REQ-023 ARESET high at a rising ACLK edge SHALL, in any state including mid-burst, force IDLE, empty FIFO, zero pointers/counters; AWVALID, WVALID, WLAST, BREADY, S_READY, TXN_DONE, ERROR, OVERFLOW = 0; INIT edge register = 0.

Verification (C_M_AXI_BURST_LEN=4, C_BUF_WORDS=16, C_NUM_CHANNELS=4, base 0x4000_0000, slave VIP always ready)
REQ-024 One-shot, 16 samples chan=i%4, data=0x100+i -> 4 bursts at 0x4000_0000/10/20/30, AWLEN=3, word i = {16'(i%4),16'(0x100+i)}, TXN_DONE=1, ERROR=0, S_READY=0 after 16 accepts.
REQ-025 Continuous, 24 samples then STOP -> 6 bursts, 5th at 0x4000_0000 (wrap), 6th at 0x4000_0010, then TXN_DONE=1.
REQ-026 Slave returns SLVERR on 2nd burst -> ERROR=1 sticky, capture still completes 4 bursts, next start clears ERROR.
REQ-027 AWREADY/WREADY withheld 100 cycles with S_VALID continuous -> FIFO fills at 64, OVERFLOW=1, no beat lost/duplicated in written data.
REQ-028 ARESET pulsed during DATA beat 2 -> next cycle all outputs 0, state IDLE; new start produces correct burst at 0x4000_0000.
REQ-029 INIT held high 50 cycles -> exactly one capture; STOP asserted mid-DATA -> burst finishes with WLAST, then DONE.
